// File: rtl/fila_writer.sv
// Write-side controller for the 8-entry, 4-bit shift queue: turns push/flush
// requests into a setup-strobe-recover write sequence and tracks queue fill.
module fila_writer #(
    parameter int STROBE_CYCLES = 1
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_push,
    input  logic [3:0] i_code,
    input  logic       i_flush,
    output logic       o_ready,
    output logic [3:0] o_ram_data,
    output logic       o_ram_write,
    output logic [3:0] o_fill_count,
    output logic       o_pair_valid,
    output logic       o_done
);

    localparam int SCW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [SCW-1:0] SC_LAST = SCW'(STROBE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_RECOVER
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_flush;
    logic [2:0]     r_fcnt;
    logic [SCW-1:0] r_scnt;
    logic           w_accept;
    logic           w_strobe_end;
    logic           w_finish;
    logic [3:0]     w_fill_nxt;

    always_comb begin
        w_next       = r_state;
        w_accept     = 1'b0;
        w_strobe_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_flush || i_push) begin
                    w_accept = 1'b1;
                    w_next   = S_SETUP;
                end
            end
            S_SETUP:  w_next = S_STROBE;
            S_STROBE: begin
                if (r_scnt == SC_LAST) begin
                    w_strobe_end = 1'b1;
                    w_next       = S_RECOVER;
                end
            end
            S_RECOVER: w_next = (r_flush && r_fcnt != 3'd0) ? S_SETUP : S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from next-state values, so done/fill land in RECOVER.
    assign w_finish = w_strobe_end && (!r_flush || r_fcnt == 3'd0);

    always_comb begin
        w_fill_nxt = o_fill_count;
        if (w_finish) begin
            if (r_flush)
                w_fill_nxt = 4'd0;
            else if (o_fill_count != 4'd8)
                w_fill_nxt = o_fill_count + 4'd1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= S_IDLE;
            r_flush      <= 1'b0;
            r_fcnt       <= 3'd0;
            r_scnt       <= '0;
            o_ready      <= 1'b1;
            o_ram_data   <= 4'd0;
            o_ram_write  <= 1'b0;
            o_fill_count <= 4'd0;
            o_pair_valid <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            r_state      <= w_next;
            o_ready      <= (w_next == S_IDLE);
            o_ram_write  <= (w_next == S_STROBE);
            o_done       <= w_finish;
            o_fill_count <= w_fill_nxt;
            o_pair_valid <= (w_fill_nxt == 4'd8);
            if (w_accept) begin
                r_flush    <= i_flush;
                o_ram_data <= i_flush ? 4'd0 : i_code;
                if (i_flush)
                    r_fcnt <= 3'd7;
            end
            if (r_state == S_STROBE)
                r_scnt <= r_scnt + 1'b1;
            else
                r_scnt <= '0;
            if (r_state == S_RECOVER && r_flush && r_fcnt != 3'd0)
                r_fcnt <= r_fcnt - 3'd1;
        end
    end

endmodule

// File: doc/fila_writer.md
# fila_writer

Write-side controller for the 8-entry, 4-bit shift queue. Turns a single-cycle push/flush request into a clean, glitch-free rising-edge write strobe with stable data. Tracks how many valid entries the queue holds, and tells the consumer when the two oldest outputs hold real data. Sits between the game/control FSM that produces 4-bit codes and the queue's `data_in` / `write` pins.

## Interface
- `STROBE_CYCLES`, default 1: number of cycles `ram_write` stays high per insertion (≥1).
- `clock` in 1: single system clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `push` in 1: insert request; accepted only in the cycle where `ready`=1.
- `code` in 4: value to insert; sampled in the accept cycle.
- `flush` in 1: fill-with-zeros request; accepted only when `ready`=1; has priority over `push`.
- `ready` out 1: 1 only in IDLE.
- `ram_data` out 4: drives the queue's `data_in`.
- `ram_write` out 1: drives the queue's `write`.
- `fill_count` out 4: valid entries in the queue, 0..8, saturating.
- `pair_valid` out 1: 1 when `fill_count`=8, i.e. both oldest queue outputs are real data.
- `done` out 1: one-cycle pulse at the end of each push, and at the end of a whole flush.

## Operation
- All outputs are registered, with no combinational path from inputs to outputs.
- Reset values: `ready`=1, `ram_data`=0, `ram_write`=0, `fill_count`=0, `pair_valid`=0, `done`=0, state IDLE, flush counter 0.
- FSM states: IDLE, SETUP, STROBE, RECOVER.
- **IDLE**
  - `flush`=1 → latch `ram_data`=0, set flush counter to 7, go to SETUP.
  - else `push`=1 → latch `ram_data`=`code`, go to SETUP.
  - Requests outside IDLE are ignored. They are not queued.
- **SETUP**: `ram_write`=0 for one cycle, so data is stable before the edge. Go to STROBE.
- **STROBE**: `ram_write`=1 for `STROBE_CYCLES` cycles, timed by a strobe counter. Go to RECOVER.
- **RECOVER**: `ram_write`=0 for one cycle.
  - Push: `fill_count` increments, saturating at 8. `done`=1. Go to IDLE.
  - Flush with counter > 0: decrement the counter, go to SETUP. `ram_data` stays 0; `done`=0.
  - Flush with counter = 0: `fill_count` := 0, `done`=1, go to IDLE.
- `pair_valid` is a registered copy of (`fill_count` == 8), updated in the same cycle as `fill_count`.
- `ram_data` holds its last value in IDLE and does not return to 0.
- The queue itself has no reset, so reset does not clear its contents.
  - After reset, `fill_count`=0 and `pair_valid`=0 regardless of stale queue data.
  - The control FSM issues `flush` after reset whenever stale data matters.

## Timing
- Push accepted in cycle 0. With `STROBE_CYCLES`=1:
  - Cycle 1: SETUP, `ram_write`=0, `ram_data`=code.
  - Cycle 2: STROBE, `ram_write`=1; the queue shifts on this rising edge.
  - Cycle 3: RECOVER, `done`=1, `fill_count` updated.
  - Cycle 4: IDLE, `ready`=1.
- General push latency is accept to `done` = 2 + `STROBE_CYCLES` cycles. Back-to-back pushes are spaced 3 + `STROBE_CYCLES` cycles apart.
- Flush takes 8 × (2 + `STROBE_CYCLES`) cycles from the first SETUP to the final RECOVER. That is 8 rising edges on `ram_write`, each preceded by ≥1 low cycle.
- `ram_write` never toggles in the same cycle as a `ram_data` change. Data changes only on the IDLE→SETUP transition.
- Simultaneous `push` and `flush` in IDLE: the flush is performed and the push is dropped.
- Reset asserted mid-operation: `ram_write` drops to 0 asynchronously. No extra rising edge is produced, and a partial flush is abandoned.
- `fill_count` at 8 plus a further push: it stays 8, while the queue still shifts.

## Test plan
- Reset, then 3 pushes of 4'h1, 4'h2, 4'h3 → three `ram_write` pulses, each 1 cycle high after a 1-cycle setup. `done` pulses 3 times. `fill_count`=3, `pair_valid`=0.
- 8 pushes of 4'h1..4'h8 → `fill_count`=8 and `pair_valid`=1 in the RECOVER of the 8th push. The queue's oldest/second-oldest outputs read 4'h1/4'h2.
- With `fill_count`=8, push 4'h9 → `fill_count` stays 8. Queue outputs read 4'h2/4'h3.
- Flush from `fill_count`=5 → exactly 8 rising edges on `ram_write` with `ram_data`=0. Single `done` after 8×3=24 cycles. `fill_count`=0, queue outputs 0/0.
- `push` and `flush` both asserted in IDLE, and `push` asserted while busy → the flush occurs, and no extra insertion is ever observed.
- Reset pulsed while `ram_write`=1 in the middle of a flush → `ram_write`=0 immediately, all outputs at reset values, no further edges. A subsequent push behaves normally.
- `STROBE_CYCLES`=3 → `ram_write` is high for exactly 3 cycles per insert, and push latency is 5 cycles.
